// File: rtl/instr_issue_unit_if.sv
// Bundle between the fetch/issue unit, its instruction memory and the decoder.
// master: the issue unit (drives imem request and the decode-side head).
// slave : the environment (memory data, redirect and decode ready).
interface instr_issue_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [5:0]        out_op;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;
  logic [CW-1:0]     fifo_count;

  modport master (
    output imem_rd, imem_addr,
    input  imem_data,
    input  redirect, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr, out_op, out_pc, halted, fifo_count
  );

  modport slave (
    input  imem_rd, imem_addr,
    output imem_data,
    output redirect, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr, out_op, out_pc, halted, fifo_count
  );
endinterface

// File: rtl/instr_issue_unit.sv
// Fetch/issue front end: PC, 1-cycle sync imem read, DEPTH-entry FIFO to decode.
// Latency: 2 cycles from imem_rd to out_valid; 1 fetch/cycle when decode drains.
// Backpressure: fetch stalls when FIFO entries + in-flight word reach DEPTH.
// Ports: clk, rst (sync, active-high); bus (master): imem_rd/imem_addr/imem_data,
//   redirect/redirect_pc, out_valid/out_ready/out_instr/out_op/out_pc, halted, fifo_count.
module instr_issue_unit #(
  parameter int               ADDR_W   = 8,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]       HALT_OP  = 6'd63
) (
  input logic               clk,
  input logic               rst,
  instr_issue_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tag;       // PC of the word currently in flight
  logic              inflight;
  logic              stop;
  logic              halted_q;

  logic [CW:0]       credit_used;
  logic              fetch, push, pop, head_vld, resp_halt;
  entry_t            head;

  // The in-flight word already owns a slot, so the FIFO can never overflow.
  assign credit_used = {1'b0, count} + (CW+1)'(inflight);
  assign fetch       = !rst && !bus.redirect && !stop && (credit_used < (CW+1)'(DEPTH));

  // A response arriving after the HALT word was captured is the speculative
  // fetch issued alongside it; it is dropped. Redirect/rst squash via priority below.
  assign push      = inflight && !stop;
  assign resp_halt = push && (bus.imem_data[31:26] == HALT_OP);

  assign head     = mem[rd_ptr];
  assign head_vld = (count != '0) && !halted_q;
  assign pop      = head_vld && bus.out_ready;

  assign bus.imem_rd    = fetch;
  assign bus.imem_addr  = pc;
  assign bus.out_valid  = head_vld;
  assign bus.out_instr  = head_vld ? head.instr : 32'd0;
  assign bus.out_op     = bus.out_instr[31:26];
  assign bus.out_pc     = head_vld ? head.pc : '0;
  assign bus.halted     = halted_q;
  assign bus.fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      stop     <= 1'b0;
      halted_q <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      // Low two bits of the target are masked: fetch is word aligned.
      pc       <= bus.redirect_pc & ~ADDR_W'(3);
      inflight <= 1'b0;
      stop     <= 1'b0;
      halted_q <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= fetch;
      if (fetch) begin
        pc  <= pc + ADDR_W'(4);
        tag <= pc;
      end
      if (push) begin
        mem[wr_ptr] <= '{instr: bus.imem_data, pc: tag};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (resp_halt) begin
        stop <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (head.instr[31:26] == HALT_OP) begin
          halted_q <= 1'b1;
        end
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_instr_issue_unit.sv
module tb_instr_issue_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_issue_unit_if #(.ADDR_W(8), .DEPTH(4)) bus  ();
  instr_issue_unit_if #(.ADDR_W(8), .DEPTH(4)) wbus ();

  instr_issue_unit #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00), .HALT_OP(6'd63)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  instr_issue_unit #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hF8), .HALT_OP(6'd63)) u_wrap (
    .clk(clk), .rst(rst), .bus(wbus)
  );

  logic [31:0] imem [64];

  // Synchronous instruction memory models, 1-cycle read latency.
  always @(posedge clk) if (bus.imem_rd)  bus.imem_data  <= imem[bus.imem_addr[7:2]];
  always @(posedge clk) if (wbus.imem_rd) wbus.imem_data <= imem[wbus.imem_addr[7:2]];

  typedef struct packed {
    logic [5:0]  op;
    logic [7:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [5:0] stream_op [8] = '{6'd54, 6'd39, 6'd40, 6'd41, 6'd42, 6'd31, 6'd32, 6'd0};

  function automatic logic [31:0] mkword(int idx, logic [5:0] op);
    return {op, 18'h0, 8'(idx)};
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 64; i++)
      imem[i] = mkword(i, (i < 8) ? stream_op[i] : 6'((i % 50) + 1));
  endtask

  function automatic exp_t mkexp(int idx);
    exp_t e;
    e.instr = imem[idx];
    e.op    = imem[idx][31:26];
    e.pc    = 8'(idx * 4);
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;  bus.redirect_pc = 8'h00;
    wbus.redirect = 1'b0; wbus.redirect_pc = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0; wbus.out_ready = 1'b0;
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", bus.imem_rd); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    checks++; if ({bus.out_instr, bus.out_op, bus.out_pc} !== 46'd0) begin errors++; $display("FAIL reset_head: instr=%h op=%0d pc=%h want all 0", bus.out_instr, bus.out_op, bus.out_pc); end
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", bus.imem_addr); end
    checks++; if (wbus.imem_addr !== 8'hF8) begin errors++; $display("FAIL reset_addr_wrap: got %h want f8", wbus.imem_addr); end
  endtask

  task automatic test_stream();
    exp_t e;
    init_mem();
    bus.out_ready = 1'b1;
    do_reset();
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      e = mkexp(i); e.op = stream_op[i]; sb.push_back(e);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_lat1: valid=%b want 0", bus.out_valid); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL stream_thru: cycle %0d valid=%b want 1", i, bus.out_valid);
      end else begin
        e = sb.pop_front();
        if (bus.out_op !== e.op || bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          errors++;
          $display("FAIL stream_word: op=%0d pc=%h instr=%h want op=%0d pc=%h instr=%h",
                   bus.out_op, bus.out_pc, bus.out_instr, e.op, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int cnt_m, inf_m;
    logic rd_m;
    init_mem();
    bus.out_ready = 1'b0;
    do_reset();
    sb.delete();
    for (int i = 0; i < 10; i++) sb.push_back(mkexp(i));
    cnt_m = 0; inf_m = 0;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rd_m = (cnt_m + inf_m < 4);
      @(negedge clk);
      cnt_m = cnt_m + inf_m;
      inf_m = int'(rd_m);
      rd_m  = (cnt_m + inf_m < 4);
      checks++;
      if (bus.fifo_count !== 3'(cnt_m) || bus.imem_rd !== rd_m) begin
        errors++; $display("FAIL bp_credit: cycle %0d count=%0d rd=%b want count=%0d rd=%b",
                           c, bus.fifo_count, bus.imem_rd, cnt_m, rd_m);
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.out_op !== 6'd54 || bus.out_pc !== 8'h00) begin
          errors++; $display("FAIL bp_head: op=%0d pc=%h want op=54 pc=00", bus.out_op, bus.out_pc);
        end
      end
    end
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL bp_full: count=%0d want 4", bus.fifo_count); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      if (bus.out_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_op !== e.op || bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          errors++; $display("FAIL bp_drain: op=%0d pc=%h want op=%0d pc=%h", bus.out_op, bus.out_pc, e.op, e.pc);
        end
      end
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_timeout: %0d words left want 0", sb.size()); end
  endtask

  task automatic test_redirect();
    exp_t e;
    init_mem();
    bus.out_ready = 1'b0;
    do_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL redir_pre: count=%0d want 3", bus.fifo_count); end
    bus.redirect = 1'b1; bus.redirect_pc = 8'h13;
    #1;
    checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL redir_rd: rd=%b want 0", bus.imem_rd); end
    @(negedge clk);
    bus.redirect = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: count=%0d valid=%b want 0 0", bus.fifo_count, bus.out_valid); end
    checks++; if (bus.imem_addr !== 8'h10) begin errors++; $display("FAIL redir_addr: got %h want 10", bus.imem_addr); end
    sb.delete();
    for (int i = 4; i < 7; i++) sb.push_back(mkexp(i));
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_op !== e.op || bus.out_pc !== e.pc) begin
          errors++; $display("FAIL redir_word: op=%0d pc=%h want op=%0d pc=%h", bus.out_op, bus.out_pc, e.op, e.pc);
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL redir_timeout: %0d words left want 0", sb.size()); end
  endtask

  task automatic test_halt();
    exp_t e;
    logic saw_halt, done;
    init_mem();
    imem[3] = mkword(3, 6'd63);
    bus.out_ready = 1'b1;
    do_reset();
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(mkexp(i));
    saw_halt = 1'b0; done = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (saw_halt) begin
        checks++;
        if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL halt_flag: halted=%b valid=%b want 1 0", bus.halted, bus.out_valid);
        end
        done = 1'b1;
      end else if (bus.out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL halt_extra: pc=%h op=%0d want no word", bus.out_pc, bus.out_op);
        end else begin
          e = sb.pop_front();
          if (bus.out_op !== e.op || bus.out_pc !== e.pc) begin
            errors++; $display("FAIL halt_word: op=%0d pc=%h want op=%0d pc=%h", bus.out_op, bus.out_pc, e.op, e.pc);
          end
          if (e.op == 6'd63) saw_halt = 1'b1;
        end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL halt_timeout: halt not seen, %0d words left want 0", sb.size()); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_rd !== 1'b0 || bus.out_valid !== 1'b0 || bus.halted !== 1'b1) begin
        errors++; $display("FAIL halt_idle: rd=%b valid=%b halted=%b want 0 0 1", bus.imem_rd, bus.out_valid, bus.halted);
      end
    end
    bus.redirect = 1'b1; bus.redirect_pc = 8'h00;
    @(negedge clk);
    bus.redirect = 1'b0;
    checks++; if (bus.halted !== 1'b0 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL halt_redir: halted=%b addr=%h want 0 00", bus.halted, bus.imem_addr); end
    sb.delete();
    sb.push_back(mkexp(0)); sb.push_back(mkexp(1));
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_op !== e.op || bus.out_pc !== e.pc) begin
          errors++; $display("FAIL halt_refetch: op=%0d pc=%h want op=%0d pc=%h", bus.out_op, bus.out_pc, e.op, e.pc);
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_refetch_timeout: %0d words left want 0", sb.size()); end
    init_mem();
  endtask

  task automatic test_wrap();
    exp_t e;
    init_mem();
    wbus.out_ready = 1'b1;
    do_reset();
    sb.delete();
    e = mkexp(62); e.pc = 8'hF8; sb.push_back(e);
    e = mkexp(63); e.pc = 8'hFC; sb.push_back(e);
    sb.push_back(mkexp(0));
    sb.push_back(mkexp(1));
    rst = 1'b0;
    for (int c = 0; c < 15 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (wbus.out_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (wbus.out_pc !== e.pc || wbus.out_instr !== e.instr) begin
          errors++; $display("FAIL wrap_word: pc=%h instr=%h want pc=%h instr=%h", wbus.out_pc, wbus.out_instr, e.pc, e.instr);
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_timeout: %0d words left want 0", sb.size()); end
    wbus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    init_mem();
    bus.out_ready = 1'b0;
    do_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL rmid_pre: count=%0d want 3", bus.fifo_count); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.imem_addr !== 8'h00 || bus.imem_rd !== 1'b0) begin
      errors++; $display("FAIL rmid_state: valid=%b count=%0d addr=%h rd=%b want 0 0 00 0",
                         bus.out_valid, bus.fifo_count, bus.imem_addr, bus.imem_rd);
    end
    sb.delete();
    for (int i = 0; i < 3; i++) sb.push_back(mkexp(i));
    bus.out_ready = 1'b1;
    rst = 1'b0;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_op !== e.op || bus.out_pc !== e.pc) begin
          errors++; $display("FAIL rmid_word: op=%0d pc=%h want op=%0d pc=%h", bus.out_op, bus.out_pc, e.op, e.pc);
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rmid_timeout: %0d words left want 0", sb.size()); end
  endtask

  initial begin
    rst = 1'b1;
    init_mem();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
